// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if -- handshake and data bundle between the EX/MEM buffer,
// the memory-access stage and the MEM/WB buffer.
//
// Parameter:
//   S          data word MSB index (word width S+1, S >= 15)
// Signals (driven by master = upstream/downstream side, slave = stage):
//   in_valid   upstream entry present                       master -> slave
//   in_ready   stage can accept (high only in IDLE)         slave  -> master
//   InCtrl     write-back control, 4'h0 = bubble            master -> slave
//   MemOp      000 PASS, 001 LW, 010 LB, 011 SW, 100 SB     master -> slave
//   Addr       byte address, word Addr[7:1], byte Addr[0]   master -> slave
//   StoreData  store source                                 master -> slave
//   AluResult  result forwarded on PASS                     master -> slave
//   ForwardIn  destination register tag                     master -> slave
//   out_valid  one-cycle pulse, outputs valid               slave  -> master
//   OutWord, OutByte, ForwardOut, WB   registered results   slave  -> master
//   misalign   registered, only with MEM_ALIGN_CHECK_EN     slave  -> master
// Optional feature macro: MEM_ALIGN_CHECK_EN

interface mem_access_stage_if #(
    parameter int S = 15
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   InCtrl;
    logic [2:0]   MemOp;
    logic [7:0]   Addr;
    logic [S:0]   StoreData;
    logic [S:0]   AluResult;
    logic [3:0]   ForwardIn;
    logic         out_valid;
    logic [S:0]   OutWord;
    logic [7:0]   OutByte;
    logic [3:0]   ForwardOut;
    logic [3:0]   WB;
`ifdef MEM_ALIGN_CHECK_EN
    logic         misalign;

    modport master (
        output in_valid, InCtrl, MemOp, Addr, StoreData, AluResult, ForwardIn,
        input  in_ready, out_valid, OutWord, OutByte, ForwardOut, WB, misalign
    );

    modport slave (
        input  in_valid, InCtrl, MemOp, Addr, StoreData, AluResult, ForwardIn,
        output in_ready, out_valid, OutWord, OutByte, ForwardOut, WB, misalign
    );
`else
    modport master (
        output in_valid, InCtrl, MemOp, Addr, StoreData, AluResult, ForwardIn,
        input  in_ready, out_valid, OutWord, OutByte, ForwardOut, WB
    );

    modport slave (
        input  in_valid, InCtrl, MemOp, Addr, StoreData, AluResult, ForwardIn,
        output in_ready, out_valid, OutWord, OutByte, ForwardOut, WB
    );
`endif
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage -- pipeline memory-access stage with a 128-word data RAM.
//
// Accepts one EX/MEM entry at a time (in_valid while in_ready), performs the
// PASS / LW / LB / SW / SB operation and presents registered results with a
// one-cycle out_valid pulse. PASS and bubbles respond one edge after accept,
// memory operations two edges after accept. No back-pressure downstream.
//
// Parameter:
//   S      data word MSB index (word width S+1, S >= 15 so two byte lanes fit)
// Ports:
//   clk    single clock, rising edge
//   rst    synchronous, active-high reset (RAM contents are kept)
//   bus    mem_access_stage_if.slave -- handshake, request and result signals
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   When defined, LW/SW with Addr[0]=1 are flagged on bus.misalign, do not
//   write the RAM and return zero data with WB=0.

module mem_access_stage #(
    parameter int S = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_access_stage_if.slave    bus
);

    localparam int W = S + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_LW   = 3'b001,
        OP_LB   = 3'b010,
        OP_SW   = 3'b011,
        OP_SB   = 3'b100
    } mem_op_e;

    state_e       state;

    // Entry captured at accept; only the memory path needs it after that edge.
    logic [2:0]   op_q;
    logic [3:0]   ctrl_q;
    logic [7:0]   addr_q;
    logic [S:0]   sdata_q;
    logic [3:0]   fwd_q;

    logic [S:0]   ram [0:127];
    logic [S:0]   rd_word;
    logic [S:0]   wr_word;
    logic         ram_we;
    logic         accept;
    logic         in_is_mem;
    logic         misal_acc;
    logic [7:0]   sel_byte;

    assign bus.in_ready = (state == IDLE);
    assign accept       = (state == IDLE) && bus.in_valid;
    assign in_is_mem    = (bus.MemOp == OP_LW) || (bus.MemOp == OP_LB) ||
                          (bus.MemOp == OP_SW) || (bus.MemOp == OP_SB);

`ifdef MEM_ALIGN_CHECK_EN
    assign misal_acc = ((op_q == OP_LW) || (op_q == OP_SW)) && addr_q[0];
`else
    assign misal_acc = 1'b0;
`endif

    // Byte lane selected by the captured address: Addr[0]=0 -> bits 7:0.
    assign sel_byte = addr_q[0] ? rd_word[15:8] : rd_word[7:0];

    // A byte store is a read-modify-write of the word read at accept, so the
    // unselected lane is written back unchanged.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        wr_word = sdata_q;
        if (op_q == OP_SB) begin
            wr_word = rd_word;
            if (addr_q[0]) begin
                wr_word[15:8] = sdata_q[7:0];
            end else begin
                wr_word[7:0]  = sdata_q[7:0];
            end
        end
    end

    // rst in ACCESS kills the write so a reset mid-store leaves memory intact.
    assign ram_we = (state == ACCESS) && !rst && !misal_acc &&
                    ((op_q == OP_SW) || (op_q == OP_SB));

    // NOTE: the data RAM has no reset; its contents must survive rst, and a
    // resettable array would also prevent mapping onto a block RAM.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[addr_q[7:1]] <= wr_word;
        end
        // Synchronous read launched at accept; data is ready in ACCESS.
        if (accept) begin
            rd_word <= ram[bus.Addr[7:1]];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.out_valid  <= 1'b0;
            bus.OutWord    <= '0;
            bus.OutByte    <= '0;
            bus.ForwardOut <= '0;
            bus.WB         <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            bus.misalign   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    bus.out_valid <= 1'b0;
                    if (bus.in_valid) begin
                        op_q    <= bus.MemOp;
                        ctrl_q  <= bus.InCtrl;
                        addr_q  <= bus.Addr;
                        sdata_q <= bus.StoreData;
                        fwd_q   <= bus.ForwardIn;
                        if (in_is_mem && (bus.InCtrl != 4'h0)) begin
                            state <= ACCESS;
                        end else begin
                            // PASS and bubble skip ACCESS and respond now.
                            state         <= RESP;
                            bus.out_valid <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                            bus.misalign  <= 1'b0;
`endif
                            if (bus.InCtrl == 4'h0) begin
                                bus.OutWord    <= '0;
                                bus.OutByte    <= '0;
                                bus.ForwardOut <= '0;
                                bus.WB         <= '0;
                            end else begin
                                bus.OutWord    <= bus.AluResult;
                                bus.OutByte    <= bus.AluResult[7:0];
                                bus.ForwardOut <= bus.ForwardIn;
                                bus.WB         <= bus.InCtrl;
                            end
                        end
                    end
                end

                ACCESS: begin
                    state          <= RESP;
                    bus.out_valid  <= 1'b1;
                    bus.ForwardOut <= fwd_q;
                    bus.WB         <= ctrl_q;
`ifdef MEM_ALIGN_CHECK_EN
                    bus.misalign   <= misal_acc;
`endif
                    if (misal_acc) begin
                        bus.OutWord <= '0;
                        bus.OutByte <= '0;
                        bus.WB      <= '0;
                    end else begin
                        unique case (op_q)
                            OP_LW: begin
                                bus.OutWord <= rd_word;
                                bus.OutByte <= rd_word[7:0];
                            end
                            OP_LB: begin
                                bus.OutWord <= {{(W - 8){1'b0}}, sel_byte};
                                bus.OutByte <= sel_byte;
                            end
                            OP_SW: begin
                                bus.OutWord <= sdata_q;
                                bus.OutByte <= sdata_q[7:0];
                            end
                            default: begin
                                // OP_SB: only the stored byte is reported.
                                bus.OutWord <= '0;
                                bus.OutByte <= sdata_q[7:0];
                            end
                        endcase
                    end
                end

                RESP: begin
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end

                default: begin
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage -- directed scoreboard bench for mem_access_stage.
// The driver pushes a hand-computed expected response (including the cycle it
// must appear in) for every issued entry; a monitor pops and compares each
// out_valid pulse. Build with or without MEM_ALIGN_CHECK_EN.

module tb_mem_access_stage;

    localparam int S = 15;

    typedef struct {
        string       name;
        logic [15:0] word;
        logic [7:0]  bytev;
        logic [3:0]  fwd;
        logic [3:0]  wb;
        logic        mis;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    mem_access_stage_if #(.S(S)) bus ();

    mem_access_stage #(.S(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_latency"}, cyc, e.cyc);
                    check({e.name, "_OutWord"}, {16'h0, bus.OutWord}, {16'h0, e.word});
                    check({e.name, "_OutByte"}, {24'h0, bus.OutByte}, {24'h0, e.bytev});
                    check({e.name, "_ForwardOut"}, {28'h0, bus.ForwardOut}, {28'h0, e.fwd});
                    check({e.name, "_WB"}, {28'h0, bus.WB}, {28'h0, e.wb});
`ifdef MEM_ALIGN_CHECK_EN
                    check({e.name, "_misalign"}, {31'h0, bus.misalign}, {31'h0, e.mis});
`endif
                end
            end
        end
    end

    // Called at a negedge; returns at a negedge once in_ready is high or the
    // wait budget is spent (reported as a failure).
    task automatic wait_ready(output bit ok);
        for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) @(negedge clk);
        ok = (bus.in_ready === 1'b1);
        if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive(input logic [3:0] ctrl, input logic [2:0] op, input logic [7:0] addr,
                         input logic [15:0] sd, input logic [15:0] alu, input logic [3:0] fwd);
        bus.in_valid  = 1'b1;
        bus.InCtrl    = ctrl;
        bus.MemOp     = op;
        bus.Addr      = addr;
        bus.StoreData = sd;
        bus.AluResult = alu;
        bus.ForwardIn = fwd;
    endtask

    task automatic issue(input string name, input logic [3:0] ctrl, input logic [2:0] op,
                         input logic [7:0] addr, input logic [15:0] sd, input logic [15:0] alu,
                         input logic [3:0] fwd, input int lat,
                         input logic [15:0] ew, input logic [7:0] eb, input logic [3:0] ef,
                         input logic [3:0] ewb, input logic em);
        bit   ok;
        exp_t e;
        drive(ctrl, op, addr, sd, alu, fwd);
        wait_ready(ok);
        if (ok) begin
            e.name = name; e.word = ew; e.bytev = eb; e.fwd = ef; e.wb = ewb; e.mis = em;
            e.cyc  = cyc + lat;   // the accept edge itself counts as edge 1
            sb_q.push_back(e);
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, {31'h0, bus.out_valid}, 32'd0);
        check({tag, "_in_ready"}, {31'h0, bus.in_ready}, 32'd1);
        check({tag, "_OutWord"}, {16'h0, bus.OutWord}, 32'd0);
        check({tag, "_OutByte"}, {24'h0, bus.OutByte}, 32'd0);
        check({tag, "_ForwardOut"}, {28'h0, bus.ForwardOut}, 32'd0);
        check({tag, "_WB"}, {28'h0, bus.WB}, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check({tag, "_misalign"}, {31'h0, bus.misalign}, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bus.in_valid = 1'b0;
        drive(4'h0, 3'b000, 8'h00, 16'h0, 16'h0, 4'h0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset_init");

        //      name         ctrl  op      addr   store     alu       fwd lat  word      byte   fwd  wb   mis
        issue("pass",       4'h5, 3'b000, 8'h00, 16'h0000, 16'hBEEF, 4'h3, 1, 16'hBEEF, 8'hEF, 4'h3, 4'h5, 1'b0);
        issue("sw_10",      4'h9, 3'b011, 8'h10, 16'hCAFE, 16'h0000, 4'h1, 2, 16'hCAFE, 8'hFE, 4'h1, 4'h9, 1'b0);

        // SW 5555 to 8'h10 interrupted by a 2-edge reset during ACCESS.
        drive(4'h1, 3'b011, 8'h10, 16'h5555, 16'h0000, 4'h7);
        wait_ready(ok);
        if (ok) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset_mid_access");

        issue("lw_10_kept", 4'h2, 3'b001, 8'h10, 16'h0000, 16'h0000, 4'h4, 2, 16'hCAFE, 8'hFE, 4'h4, 4'h2, 1'b0);
        issue("sw_20",      4'h1, 3'b011, 8'h20, 16'h1234, 16'h0000, 4'h2, 2, 16'h1234, 8'h34, 4'h2, 4'h1, 1'b0);
        issue("lw_20",      4'h3, 3'b001, 8'h20, 16'h0000, 16'h0000, 4'h5, 2, 16'h1234, 8'h34, 4'h5, 4'h3, 1'b0);
        issue("sb_21",      4'h1, 3'b100, 8'h21, 16'hFFAB, 16'h0000, 4'h6, 2, 16'h0000, 8'hAB, 4'h6, 4'h1, 1'b0);
        issue("lw_20_sb",   4'h3, 3'b001, 8'h20, 16'h0000, 16'h0000, 4'h5, 2, 16'hAB34, 8'h34, 4'h5, 4'h3, 1'b0);
        issue("lb_21",      4'h7, 3'b010, 8'h21, 16'h0000, 16'h0000, 4'h8, 2, 16'h00AB, 8'hAB, 4'h8, 4'h7, 1'b0);
        issue("lb_20",      4'h7, 3'b010, 8'h20, 16'h0000, 16'h0000, 4'h8, 2, 16'h0034, 8'h34, 4'h8, 4'h7, 1'b0);
        issue("bubble_sw",  4'h0, 3'b011, 8'h20, 16'hFFFF, 16'h1111, 4'h9, 1, 16'h0000, 8'h00, 4'h0, 4'h0, 1'b0);
        issue("lw_20_bub",  4'h3, 3'b001, 8'h20, 16'h0000, 16'h0000, 4'h5, 2, 16'hAB34, 8'h34, 4'h5, 4'h3, 1'b0);
        issue("op111_pass", 4'hA, 3'b111, 8'h20, 16'hFFFF, 16'h5A5A, 4'hC, 1, 16'h5A5A, 8'h5A, 4'hC, 4'hA, 1'b0);
        issue("sw_30",      4'h1, 3'b011, 8'h30, 16'h7777, 16'h0000, 4'h1, 2, 16'h7777, 8'h77, 4'h1, 4'h1, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
        issue("sw_31_mis",  4'h1, 3'b011, 8'h31, 16'h9999, 16'h0000, 4'h2, 2, 16'h0000, 8'h00, 4'h2, 4'h0, 1'b1);
        issue("lw_30",      4'h3, 3'b001, 8'h30, 16'h0000, 16'h0000, 4'h3, 2, 16'h7777, 8'h77, 4'h3, 4'h3, 1'b0);
        issue("lw_31_mis",  4'h3, 3'b001, 8'h31, 16'h0000, 16'h0000, 4'h3, 2, 16'h0000, 8'h00, 4'h3, 4'h0, 1'b1);
`else
        issue("sw_31",      4'h1, 3'b011, 8'h31, 16'h9999, 16'h0000, 4'h2, 2, 16'h9999, 8'h99, 4'h2, 4'h1, 1'b0);
        issue("lw_30",      4'h3, 3'b001, 8'h30, 16'h0000, 16'h0000, 4'h3, 2, 16'h9999, 8'h99, 4'h3, 4'h3, 1'b0);
        issue("lw_31",      4'h3, 3'b001, 8'h31, 16'h0000, 16'h0000, 4'h3, 2, 16'h9999, 8'h99, 4'h3, 4'h3, 1'b0);
`endif
        issue("pass_last",  4'hF, 3'b000, 8'h00, 16'h0000, 16'h0F0F, 4'hE, 1, 16'h0F0F, 8'h0F, 4'hE, 4'hF, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
